sop_eval_pipe: RTL and testbench

SOP_EVAL_PIPE -- requirements
Module: sop_eval_pipe

---
 rtl/sop_pkg.sv | 27 ++
 rtl/sop_term_match.sv | 20 ++
 rtl/sop_eval_pipe.sv | 110 +++++++++++
 tb/tb_sop_eval_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sop_pkg.sv
// Shared types, defaults and helpers for the sum-of-products evaluator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sop_pkg;

    localparam int SOP_N_IN_DEF   = 12;
    localparam int SOP_N_TERM_DEF = 8;
    localparam int SOP_MAX_N_IN   = 32;

    // One programmable product term. Stored at the maximum input width;
    // bits above N_IN are always written as zero so they never take part.
    typedef struct packed {
        logic [SOP_MAX_N_IN-1:0] care;
        logic [SOP_MAX_N_IN-1:0] pol;
    } term_rec_t;

    // Index width for a table of 'value' entries, never less than one bit.
    function automatic int sop_clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sop_term_match.sv
// Evaluates one product term against an input vector.
// Latency: purely combinational.
// Backpressure: none; pure function of its inputs.
module sop_term_match
    import sop_pkg::*;
(
    input  term_rec_t               i_term,
    input  logic [SOP_MAX_N_IN-1:0] i_data,
    output logic                    o_hit
);

    logic w_enabled;
    logic w_mismatch;

    // An empty care mask means the term is switched off, not a constant 1.
    assign w_enabled  = |i_term.care;
    assign w_mismatch = |((i_data ^ i_term.pol) & i_term.care);
    assign o_hit      = w_enabled & ~w_mismatch;

endmodule

// File: rtl/sop_eval_pipe.sv
// Programmable sum-of-products evaluator with a two-stage valid/ready pipeline.
// Latency: 2 cycles from input handshake to out_valid when not stalled.
// Backpressure: each stage loads when empty or draining; in_ready falls only when both stages are held.
module sop_eval_pipe
    import sop_pkg::*;
#(
    parameter int N_IN   = SOP_N_IN_DEF,
    parameter int N_TERM = SOP_N_TERM_DEF,
    parameter int TW     = sop_clog2(N_TERM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [TW-1:0]     cfg_idx,
    input  logic [N_IN-1:0]   cfg_care,
    input  logic [N_IN-1:0]   cfg_pol,
    input  logic              cfg_inv,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic [N_TERM-1:0] out_terms
);

    term_rec_t               r_table [N_TERM];
    logic                    r_inv;

    logic                    r_s1_vld;
    logic [N_TERM-1:0]       r_s1_terms;
    logic                    r_s1_inv;

    logic                    r_s2_vld;
    logic [N_TERM-1:0]       r_s2_terms;
    logic                    r_s2_bit;

    logic [SOP_MAX_N_IN-1:0] w_data_ext;
    logic [N_TERM-1:0]       w_hits;
    logic                    w_s2_adv;
    logic                    w_s1_drain;

    assign w_data_ext = SOP_MAX_N_IN'(in_data);

    // S2 can load when empty or its result is taken this cycle; S1 drains into it.
    assign w_s2_adv   = ~r_s2_vld | out_ready;
    assign w_s1_drain = r_s1_vld & w_s2_adv;
    assign in_ready   = ~r_s1_vld | w_s1_drain;

    // Term table held in flops; a later write to the same index overwrites.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < N_TERM; t++) begin
                r_table[t] <= '0;
            end
            r_inv <= 1'b0;
        end else if (cfg_we) begin
            for (int t = 0; t < N_TERM; t++) begin
                if (cfg_idx == TW'(t)) begin
                    r_table[t].care <= SOP_MAX_N_IN'(cfg_care);
                    r_table[t].pol  <= SOP_MAX_N_IN'(cfg_pol);
                end
            end
            r_inv <= cfg_inv;
        end
    end

    for (genvar g = 0; g < N_TERM; g++) begin : g_term
        sop_term_match u_match (
            .i_term (r_table[g]),
            .i_data (w_data_ext),
            .o_hit  (w_hits[g])
        );
    end

    // S1 snapshots the term vector and inv from the table as it stands before this edge's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_terms <= '0;
            r_s1_inv   <= 1'b0;
        end else if (in_ready) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_terms <= w_hits;
                r_s1_inv   <= r_inv;
            end
        end
    end

    // S2 folds the term vector into the output bit; holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld   <= 1'b0;
            r_s2_terms <= '0;
            r_s2_bit   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_terms <= r_s1_terms;
                r_s2_bit   <= (|r_s1_terms) ^ r_s1_inv;
            end
        end
    end

    assign out_valid = r_s2_vld;
    assign out_bit   = r_s2_bit;
    assign out_terms = r_s2_terms;

endmodule

// File: tb/tb_sop_eval_pipe.sv
// Self-checking bench for sop_eval_pipe: directed scenarios plus random traffic against a table model.
// Latency: checks the 2-cycle fill latency and ordered delivery through a scoreboard.
// Backpressure: exercises out_ready stalls and output stability while held.
module tb_sop_eval_pipe;

    localparam int NI  = 12;
    localparam int NT  = 8;
    localparam int TWB = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_we;
    logic [TWB-1:0] cfg_idx;
    logic [NI-1:0]  cfg_care;
    logic [NI-1:0]  cfg_pol;
    logic           cfg_inv;
    logic           in_valid;
    logic           in_ready;
    logic [NI-1:0]  in_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_bit;
    logic [NT-1:0]  out_terms;

    always #5 clk = ~clk;

    sop_eval_pipe #(.N_IN(NI), .N_TERM(NT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_care  (cfg_care),
        .cfg_pol   (cfg_pol),
        .cfg_inv   (cfg_inv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_terms (out_terms)
    );

    // Reference model: the programmed table as plain arrays, results as a queue.
    logic [NI-1:0] m_care [NT];
    logic [NI-1:0] m_pol  [NT];
    logic          m_inv;
    logic [NT:0]   exp_q [$];
    logic          obs_bits [$];
    int            obs_cyc [$];

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            n_acc   = 0;
    logic          last_acc;
    logic          hold = 1'b0;
    logic [NT:0]   held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {out_bit, term vector} for a given input under the current model table.
    function automatic logic [NT:0] model_eval(input logic [NI-1:0] d);
        logic [NT-1:0] tv;
        logic          hit;
        logic          any;
        tv  = '0;
        any = 1'b0;
        for (int t = 0; t < NT; t++) begin
            hit = (m_care[t] != 0);
            for (int i = 0; i < NI; i++) begin
                if (m_care[t][i] && (d[i] != m_pol[t][i])) hit = 1'b0;
            end
            tv[t] = hit;
            if (hit) any = 1'b1;
        end
        return {any ^ m_inv, tv};
    endfunction

    task automatic model_clear();
        for (int t = 0; t < NT; t++) begin
            m_care[t] = '0;
            m_pol[t]  = '0;
        end
        m_inv = 1'b0;
        exp_q.delete();
    endtask

    // Called just after a falling edge with inputs already driven: account for
    // the handshakes of the coming rising edge, then advance one cycle.
    task automatic tick();
        logic [NT:0] e;
        #1;
        last_acc = 1'b0;
        if (rst) begin
            model_clear();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", {out_bit, out_terms}, held);
            end
            hold = out_valid && !out_ready;
            held = {out_bit, out_terms};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_terms", out_terms, e[NT-1:0]);
                    chk("out_bit", out_bit, e[NT]);
                end
                obs_bits.push_back(out_bit);
                obs_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_eval(in_data));
                n_acc++;
                last_acc = 1'b1;
            end
            if (cfg_we) begin
                m_care[cfg_idx] = cfg_care;
                m_pol[cfg_idx]  = cfg_pol;
                m_inv           = cfg_inv;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic cfg_write(input int idx, input logic [NI-1:0] care,
                             input logic [NI-1:0] pol, input logic inv);
        cfg_we   = 1'b1;
        cfg_idx  = TWB'(idx);
        cfg_care = care;
        cfg_pol  = pol;
        cfg_inv  = inv;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && (exp_q.size() != 0 || out_valid); k++) tick();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NI-1:0] items [4];
        int            idx;
        int            t;
        items = '{12'h003, 12'h008, 12'h018, 12'h000};

        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_care = '0; cfg_pol = '0;
        cfg_inv = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bit", out_bit, 0);
        chk("rst_out_terms", out_terms, 0);
        chk("rst_in_ready", in_ready, 1);

        // Empty table: all-ones input gives 0, with 2-cycle latency
        in_valid = 1'b1; in_data = 12'hFFF;
        tick();
        in_valid = 1'b0;
        chk("lat1_valid", out_valid, 0);
        tick();
        chk("lat2_valid", out_valid, 1);
        chk("empty_bit", out_bit, 0);
        chk("empty_terms", out_terms, 0);
        drain();

        // a&b and d&~e, streamed back to back
        cfg_write(0, 12'h003, 12'h003, 1'b0);
        cfg_write(1, 12'h018, 12'h008, 1'b0);
        obs_bits.delete(); obs_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = items[k];
            tick();
        end
        drain();
        chk("stream_count", obs_bits.size(), 4);
        if (obs_bits.size() == 4) begin
            chk("stream_b0", obs_bits[0], 1);
            chk("stream_b1", obs_bits[1], 1);
            chk("stream_b2", obs_bits[2], 0);
            chk("stream_b3", obs_bits[3], 0);
            for (int k = 0; k < 3; k++) chk("stream_consec", obs_cyc[k+1] - obs_cyc[k], 1);
        end

        // NOR mode
        cfg_write(0, 12'h003, 12'h003, 1'b1);
        obs_bits.delete();
        in_valid = 1'b1; in_data = 12'h000;
        tick();
        drain();
        chk("inv_count", obs_bits.size(), 1);
        if (obs_bits.size() == 1) chk("inv_bit", obs_bits[0], 1);

        // Stall: 5 cycles of out_ready=0 with 4 inputs on offer
        out_ready = 1'b0; n_acc = 0; idx = 0;
        repeat (5) begin
            in_valid = 1'b1; in_data = items[idx];
            tick();
            if (last_acc && idx < 3) idx++;
        end
        chk("bp_accepted", n_acc, 2);
        chk("bp_in_ready", in_ready, 0);
        obs_bits.delete();
        drain();
        chk("bp_delivered", obs_bits.size(), 2);

        // Write in the same cycle as an accept: old table applies to that input
        obs_bits.delete();
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_care = 12'h003; cfg_pol = 12'h000; cfg_inv = 1'b1;
        in_valid = 1'b1; in_data = 12'h003;
        tick();
        cfg_we = 1'b0;
        in_data = 12'h003;
        tick();
        drain();
        chk("wr_same_count", obs_bits.size(), 2);
        if (obs_bits.size() == 2) begin
            chk("wr_same_old", obs_bits[0], 0);
            chk("wr_same_new", obs_bits[1], 1);
        end

        // Random traffic, config writes and backpressure
        for (int k = 0; k < 600; k++) begin
            cfg_we = ($urandom_range(0, 7) == 0);
            if (cfg_we) begin
                cfg_idx  = TWB'($urandom_range(0, NT - 1));
                cfg_care = NI'($urandom & $urandom);
                cfg_pol  = NI'($urandom);
                cfg_inv  = ($urandom_range(0, 3) == 0);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) begin
                t = $urandom_range(0, NT - 1);
                in_data = m_pol[t] ^ (NI'($urandom) & ~m_care[t]);
            end else begin
                in_data = NI'($urandom);
            end
            tick();
        end
        cfg_we = 1'b0;
        drain();

        // Reset with two results in flight
        cfg_write(2, 12'h001, 12'h000, 1'b0);
        out_ready = 1'b0; n_acc = 0;
        in_valid = 1'b1; in_data = 12'h0F0;
        tick();
        in_data = 12'h00E;
        tick();
        chk("inflight_acc", n_acc, 2);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            chk("post_rst_valid", out_valid, 0);
            tick();
        end
        obs_bits.delete();
        in_valid = 1'b1; in_data = 12'h000;
        tick();
        drain();
        chk("post_rst_count", obs_bits.size(), 1);
        if (obs_bits.size() == 1) chk("post_rst_cleared", obs_bits[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
